// File: rtl/ct_ciu_prf_recv.sv
// ct_ciu_prf_recv: buffers L2C prefetch requests in an in-order FIFO, drops duplicates,
// and issues survivors one at a time to the CIU request arbiter.
module ct_ciu_prf_recv #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 34
) (
  input  logic              l2c_pref_clk,
  input  logic              cpurst_b,
  input  logic              l2c_ciu_prf_vld,
  input  logic [ADDR_W-1:0] l2c_ciu_prf_addr,
  input  logic [2:0]        l2c_ciu_prf_prot,
  output logic              ciu_l2c_prf_ready,
  input  logic              ciu_prf_en,
  input  logic              ciu_prf_flush,
  output logic              prf_req_vld,
  output logic [ADDR_W-1:0] prf_req_addr,
  output logic [2:0]        prf_req_prot,
  input  logic              prf_req_grant,
  output logic              prf_buf_empty,
  output logic [7:0]        prf_drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0]       wptr, rptr, cnt;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [2:0]        mem_prot [DEPTH];
  logic [ADDR_W-1:0] last_addr;
  logic              last_vld, full, empty, accept, dup, push, pop, discard;
  logic [PW-1:0]     off;
  assign cnt     = wptr - rptr;
  assign full    = (wptr[PW-1:0] == rptr[PW-1:0]) && (wptr[PW] != rptr[PW]);
  assign empty   = wptr == rptr;
  assign accept  = l2c_ciu_prf_vld && !full;
  assign push    = accept && ciu_prf_en && !ciu_prf_flush && !dup;
  assign discard = accept && !ciu_prf_flush && (!ciu_prf_en || dup);
  assign pop     = !empty && prf_req_grant && !ciu_prf_flush;
  assign ciu_l2c_prf_ready = !full;
  assign prf_req_vld       = !empty;
  assign prf_buf_empty     = empty;
  assign prf_req_addr      = empty ? '0 : mem_addr[rptr[PW-1:0]];
  assign prf_req_prot      = empty ? '0 : mem_prot[rptr[PW-1:0]];
  // An entry is live when its offset from the read pointer is below the occupancy.
  always_comb begin
    dup = last_vld && (last_addr == l2c_ciu_prf_addr);
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rptr[PW-1:0];
      dup = dup || (({1'b0, off} < cnt) && (mem_addr[i] == l2c_ciu_prf_addr));
    end
  end
  always_ff @(posedge l2c_pref_clk)
    if (push) begin
      mem_addr[wptr[PW-1:0]] <= l2c_ciu_prf_addr;
      mem_prot[wptr[PW-1:0]] <= l2c_ciu_prf_prot;
    end
  always_ff @(posedge l2c_pref_clk or negedge cpurst_b)
    if (!cpurst_b) begin
      wptr         <= '0;
      rptr         <= '0;
      last_vld     <= 1'b0;
      last_addr    <= '0;
      prf_drop_cnt <= '0;
    end else begin
      wptr <= ciu_prf_flush ? '0 : wptr + (PW+1)'(push);
      rptr <= ciu_prf_flush ? '0 : rptr + (PW+1)'(pop);
      last_vld <= ciu_prf_flush ? 1'b0 : (last_vld || pop);
      if (pop) last_addr <= mem_addr[rptr[PW-1:0]];
      if (discard && prf_drop_cnt != 8'hFF) prf_drop_cnt <= prf_drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_ct_ciu_prf_recv.sv
// tb_ct_ciu_prf_recv: directed scenario tests for the prefetch receiver.
module tb_ct_ciu_prf_recv;
  logic        clk = 0, rst_n = 0;
  logic        vld = 0, en = 1, flush = 0, grant = 0;
  logic [33:0] addr = '0;
  logic [2:0]  prot = '0;
  logic        ready, req_vld, empty;
  logic [33:0] req_addr;
  logic [2:0]  req_prot;
  logic [7:0]  drop;
  int total = 0, bad = 0;

  ct_ciu_prf_recv dut (
    .l2c_pref_clk(clk), .cpurst_b(rst_n),
    .l2c_ciu_prf_vld(vld), .l2c_ciu_prf_addr(addr), .l2c_ciu_prf_prot(prot),
    .ciu_l2c_prf_ready(ready), .ciu_prf_en(en), .ciu_prf_flush(flush),
    .prf_req_vld(req_vld), .prf_req_addr(req_addr), .prf_req_prot(req_prot),
    .prf_req_grant(grant), .prf_buf_empty(empty), .prf_drop_cnt(drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    step(); step();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", ready); end
    total++; if (req_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0h exp=0", req_vld); end
    total++; if (req_addr !== 34'h0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", req_addr); end
    total++; if (req_prot !== 3'h0) begin bad++; $display("FAIL reset_prot got=%0h exp=0", req_prot); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0h exp=1", empty); end
    total++; if (drop !== 8'h0) begin bad++; $display("FAIL reset_drop got=%0h exp=0", drop); end
    rst_n = 1;
    step();
  endtask

  task automatic test_single();
    grant = 1; vld = 1; addr = 34'h100; prot = 3'b111;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0h exp=1", ready); end
    step();
    vld = 0;
    total++; if (req_vld !== 1'b1) begin bad++; $display("FAIL single_vld got=%0h exp=1", req_vld); end
    total++; if (req_addr !== 34'h100) begin bad++; $display("FAIL single_addr got=%0h exp=100", req_addr); end
    total++; if (req_prot !== 3'b111) begin bad++; $display("FAIL single_prot got=%0h exp=7", req_prot); end
    step();
    total++; if (req_vld !== 1'b0) begin bad++; $display("FAIL single_vld_off got=%0h exp=0", req_vld); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%0h exp=1", empty); end
    grant = 0;
  endtask

  task automatic test_fill();
    grant = 0; prot = 3'b010;
    for (int k = 0; k < 4; k++) begin
      vld = 1; addr = 34'h10 + 34'(k);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%0h exp=1", k, ready); end
      step();
    end
    addr = 34'h14;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%0h exp=0", ready); end
    step();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL fill_held got=%0h exp=0", ready); end
    total++; if (req_addr !== 34'h10) begin bad++; $display("FAIL fill_head_stable got=%0h exp=10", req_addr); end
    grant = 1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL fill_no_bypass got=%0h exp=0", ready); end
    step();
    grant = 0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL fill_ready_rise got=%0h exp=1", ready); end
    total++; if (req_addr !== 34'h11) begin bad++; $display("FAIL fill_head1 got=%0h exp=11", req_addr); end
    step();
    vld = 0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL fill_refull got=%0h exp=0", ready); end
    grant = 1;
    for (int k = 1; k < 5; k++) begin
      total++; if (req_vld !== 1'b1 || req_addr !== 34'h10 + 34'(k)) begin bad++; $display("FAIL fill_order%0d got=%0h/%0h exp=1/%0h", k, req_vld, req_addr, 34'h10 + 34'(k)); end
      step();
    end
    grant = 0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drained got=%0h exp=1", empty); end
    total++; if (drop !== 8'd0) begin bad++; $display("FAIL fill_drop got=%0h exp=0", drop); end
  endtask

  task automatic test_dup();
    vld = 1; addr = 34'h200; step();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL dup_ready got=%0h exp=1", ready); end
    step();
    vld = 0;
    total++; if (drop !== 8'd1) begin bad++; $display("FAIL dup_drop1 got=%0h exp=1", drop); end
    total++; if (req_addr !== 34'h200) begin bad++; $display("FAIL dup_head got=%0h exp=200", req_addr); end
    grant = 1; step(); grant = 0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL dup_count1 got=%0h exp=1", empty); end
    vld = 1; addr = 34'h200; step(); vld = 0;
    total++; if (drop !== 8'd2) begin bad++; $display("FAIL dup_drop2 got=%0h exp=2", drop); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL dup_last got=%0h exp=1", empty); end
    vld = 1; addr = 34'h201; step(); vld = 0;
    total++; if (req_vld !== 1'b1 || req_addr !== 34'h201) begin bad++; $display("FAIL dup_new got=%0h/%0h exp=1/201", req_vld, req_addr); end
    total++; if (drop !== 8'd2) begin bad++; $display("FAIL dup_drop_keep got=%0h exp=2", drop); end
    grant = 1; step(); grant = 0;
  endtask

  task automatic test_disable();
    vld = 1; addr = 34'h300; step();
    en = 0;
    for (int k = 1; k < 4; k++) begin
      addr = 34'h300 + 34'(k);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL dis_ready%0d got=%0h exp=1", k, ready); end
      step();
    end
    vld = 0;
    total++; if (drop !== 8'd5) begin bad++; $display("FAIL dis_drop got=%0h exp=5", drop); end
    total++; if (req_vld !== 1'b1 || req_addr !== 34'h300) begin bad++; $display("FAIL dis_issue got=%0h/%0h exp=1/300", req_vld, req_addr); end
    grant = 1; step(); grant = 0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL dis_none_enq got=%0h exp=1", empty); end
    en = 1;
  endtask

  task automatic test_flush();
    vld = 1; addr = 34'h400; step();
    addr = 34'h401; step();
    addr = 34'h402; flush = 1; grant = 1;
    step();
    vld = 0; flush = 0; grant = 0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%0h exp=1", empty); end
    total++; if (req_vld !== 1'b0) begin bad++; $display("FAIL flush_vld got=%0h exp=0", req_vld); end
    total++; if (drop !== 8'd5) begin bad++; $display("FAIL flush_drop got=%0h exp=5", drop); end
    vld = 1; addr = 34'h300; step(); vld = 0;
    total++; if (req_vld !== 1'b1 || req_addr !== 34'h300) begin bad++; $display("FAIL flush_lastclr got=%0h/%0h exp=1/300", req_vld, req_addr); end
    grant = 1; step(); grant = 0;
  endtask

  task automatic test_saturation();
    en = 0; vld = 1;
    for (int k = 0; k < 300; k++) begin
      addr = 34'h8000 + 34'(k);
      step();
    end
    vld = 0; en = 1;
    total++; if (drop !== 8'hFF) begin bad++; $display("FAIL sat_drop got=%0h exp=ff", drop); end
  endtask

  task automatic test_back_to_back();
    grant = 1; vld = 1;
    for (int k = 0; k < 40; k++) begin
      addr = 34'h1000 + 34'(k); prot = 3'(k);
      step();
      total++; if (req_vld !== 1'b1 || req_addr !== 34'h1000 + 34'(k) || req_prot !== 3'(k)) begin bad++; $display("FAIL wrap%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, req_vld, req_addr, req_prot, 34'h1000 + 34'(k), 3'(k)); end
    end
    vld = 0; step(); grant = 0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0h exp=1", empty); end
  endtask

  task automatic test_reset_mid();
    vld = 1; addr = 34'h500; step();
    addr = 34'h501; step();
    vld = 0;
    #2 rst_n = 0;
    #1;
    total++; if (empty !== 1'b1 || req_vld !== 1'b0) begin bad++; $display("FAIL rstmid_empty got=%0h/%0h exp=1/0", empty, req_vld); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0h exp=1", ready); end
    total++; if (drop !== 8'h0) begin bad++; $display("FAIL rstmid_drop got=%0h exp=0", drop); end
    step();
    rst_n = 1;
    step();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_retained got=%0h exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_dup();
    test_disable();
    test_flush();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
